// File: rtl/decode_pkg.sv
// decode_pkg: shared types, mode constants and the one-hot-low decode helper
// for the '138-family decoders.
package decode_pkg;
   typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_e;
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
   localparam int   MAX_OUT     = 256;
   // Callers cast the result down to their own output width.
   function automatic logic [MAX_OUT-1:0] onehot_low(int unsigned a);
      return ~(MAX_OUT'(1) << a);
   endfunction
endpackage

// File: rtl/decode_scan_138_if.sv
// decode_scan_138_if: enables, mode/scan controls and decoded outputs of the
// scanning decoder; master drives the controls, slave is the decoder.
interface decode_scan_138_if #(
   parameter int ADDR_W  = 3,
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
);
   localparam int N_OUT = 1 << ADDR_W;
   logic               g1, g2a_n, g2b_n, mode, scan_en;
   logic [ADDR_W-1:0]  addr;
   logic [DWELL_W-1:0] dwell;
   logic [BLANK_W-1:0] blank;
   logic [N_OUT-1:0]   y_n;
   logic [ADDR_W-1:0]  cur_addr;
   logic               busy, frame_done;
   modport master (
      output g1, g2a_n, g2b_n, mode, addr, scan_en, dwell, blank,
      input  y_n, cur_addr, busy, frame_done
   );
   modport slave (
      input  g1, g2a_n, g2b_n, mode, addr, scan_en, dwell, blank,
      output y_n, cur_addr, busy, frame_done
   );
endinterface

// File: rtl/decode_scan_seq.sv
// decode_scan_seq: scan FSM with dwell/blank/address counters; also exposes
// its next-state view so the output register lines up with the state.
module decode_scan_seq
   import decode_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_run,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic [BLANK_W-1:0] i_blank,
   output logic [ADDR_W-1:0]  o_cur_addr,
   output logic               o_busy,
   output logic               o_frame_done,
   output logic               o_show_nxt,
   output logic               o_idle_nxt,
   output logic [ADDR_W-1:0]  o_addr_nxt
);
   scan_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [BLANK_W-1:0] r_blank, r_blank_cnt;
   logic               r_frame_done, w_show_end, w_blank_end, w_adv, w_start;
   assign w_show_end  = (r_state == SHOW) && (r_dwell_cnt == '0);
   assign w_blank_end = (r_state == BLANK) && (r_blank_cnt == '0);
   assign w_adv       = i_run && ((w_show_end && r_blank == '0) || w_blank_end);
   assign w_start     = i_run && (r_state == IDLE);
   always_comb begin
      w_state_nxt = !i_run ? IDLE :
                    (w_start || w_adv) ? SHOW :
                    w_show_end ? BLANK : r_state;
      w_addr_nxt  = (!i_run || r_state == IDLE) ? '0 :
                    w_adv ? r_addr + ADDR_W'(1) : r_addr;
   end
   // dwell and blank are captured once per step so mid-step edits wait a step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_dwell_cnt  <= '0;
         r_blank      <= '0;
         r_blank_cnt  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_frame_done <= w_adv && (&r_addr);
         if (w_start || w_adv) begin
            r_dwell_cnt <= i_dwell;
            r_blank     <= i_blank;
         end else if (r_state == SHOW && r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
         end
         if (w_show_end) r_blank_cnt <= r_blank - BLANK_W'(1);
         else if (r_state == BLANK && r_blank_cnt != '0) r_blank_cnt <= r_blank_cnt - BLANK_W'(1);
      end
   end
   assign o_cur_addr   = r_addr;
   assign o_busy       = r_state != IDLE;
   assign o_frame_done = r_frame_done;
   assign o_show_nxt   = w_state_nxt == SHOW;
   assign o_idle_nxt   = w_state_nxt == IDLE;
   assign o_addr_nxt   = w_addr_nxt;
endmodule

// File: rtl/decode_scan_138.sv
// decode_scan_138: registered '138-style decoder with direct and scan modes;
// enable gating and the y_n register live here, sequencing in decode_scan_seq.
module decode_scan_138
   import decode_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   decode_scan_138_if.slave  bus
);
   localparam int N_OUT = 1 << ADDR_W;
   logic              w_en, w_run, w_show_nxt, w_idle_nxt, w_busy, w_frame_done;
   logic [ADDR_W-1:0] w_addr_nxt, w_sel, w_cur_addr;
   logic [N_OUT-1:0]  w_dec, w_y_nxt, r_y_n;
   assign w_en  = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
   assign w_run = (bus.mode == MODE_SCAN) & bus.scan_en;
   decode_scan_seq #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .BLANK_W(BLANK_W)) u_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_run        (w_run),
      .i_dwell      (bus.dwell),
      .i_blank      (bus.blank),
      .o_cur_addr   (w_cur_addr),
      .o_busy       (w_busy),
      .o_frame_done (w_frame_done),
      .o_show_nxt   (w_show_nxt),
      .o_idle_nxt   (w_idle_nxt),
      .o_addr_nxt   (w_addr_nxt)
   );
   // Decoding the sequencer's next state keeps y_n aligned with cur_addr/busy.
   assign w_sel   = w_idle_nxt ? bus.addr : w_addr_nxt;
   assign w_dec   = N_OUT'(onehot_low(32'(w_sel)));
   assign w_y_nxt = (w_en && (w_idle_nxt || w_show_nxt)) ? w_dec : '1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_y_n <= '1;
      else r_y_n <= w_y_nxt;
   end
   assign bus.y_n        = r_y_n;
   assign bus.cur_addr   = w_cur_addr;
   assign bus.busy       = w_busy;
   assign bus.frame_done = w_frame_done;
endmodule

// File: tb/tb_decode_scan_138.sv
// tb_decode_scan_138: directed and randomized checks of decode_scan_138 against
// a schedule model (step position within a frame computed arithmetically).
module tb_decode_scan_138;
   import decode_pkg::*;
   localparam int ADDR_W = 3, DWELL_W = 8, BLANK_W = 4, N_OUT = 8;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0;
   decode_scan_138_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .BLANK_W(BLANK_W)) bus ();
   decode_scan_138 #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .BLANK_W(BLANK_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );
   always #5 clk = ~clk;
   bit         scanning = 1'b0;
   int         pos = 0, d_run = 0, b_run = 0;
   logic [7:0] exp_y = 8'hFF;
   logic [2:0] exp_addr = '0;
   logic       exp_busy = 1'b0, exp_fd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".y_n"}, 32'(bus.y_n), 32'(exp_y));
      chk({tag, ".cur_addr"}, 32'(bus.cur_addr), 32'(exp_addr));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
      chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(exp_fd));
      chk({tag, ".onehot"}, 32'($countones(~bus.y_n) <= 1), 32'd1);
   endtask

   // Predict the post-edge outputs from the current inputs, clock, then compare.
   task automatic step(input string tag);
      bit en;
      int p;
      en = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
      if (!(bus.mode == MODE_SCAN && bus.scan_en)) begin
         scanning = 1'b0;
         exp_busy = 1'b0;
         exp_addr = '0;
         exp_fd   = 1'b0;
         exp_y    = en ? ~(8'd1 << bus.addr) : 8'hFF;
      end else begin
         if (!scanning) begin
            scanning = 1'b1;
            pos      = 0;
            d_run    = int'(bus.dwell);
            b_run    = int'(bus.blank);
         end else pos++;
         p        = d_run + 1 + b_run;
         exp_addr = 3'((pos / p) % N_OUT);
         exp_busy = 1'b1;
         exp_fd   = (pos > 0) && (pos % (p * N_OUT) == 0);
         exp_y    = (en && (pos % p) <= d_run) ? ~(8'd1 << exp_addr) : 8'hFF;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_en(input logic a, input logic b, input logic c);
      bus.g1 = a;
      bus.g2a_n = b;
      bus.g2b_n = c;
   endtask

   task automatic start_scan(input int d, input int b);
      bus.dwell   = DWELL_W'(d);
      bus.blank   = BLANK_W'(b);
      bus.mode    = MODE_SCAN;
      bus.scan_en = 1'b1;
   endtask

   initial begin
      int fd_cnt;
      set_en(1, 0, 0);
      bus.mode = MODE_DIRECT;
      bus.addr = 3'd5;
      bus.scan_en = 1'b0;
      bus.dwell = '0;
      bus.blank = '0;
      // Reset state
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_release");
      chk("rst_release.df", 32'(bus.y_n), 32'hDF);
      // Direct sweep and enable gating
      for (int a = 0; a < N_OUT; a++) begin
         bus.addr = 3'(a);
         step("direct_sweep");
      end
      set_en(1, 1, 0);
      step("g2a_off");
      set_en(0, 0, 0);
      step("g1_off");
      set_en(1, 0, 1);
      step("g2b_off");
      for (int i = 0; i < 20; i++) begin
         set_en(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
         bus.addr = 3'($urandom);
         step("direct_rand");
      end
      // Scan dwell=2 blank=1, two full frames
      set_en(1, 0, 0);
      start_scan(2, 1);
      fd_cnt = 0;
      for (int i = 0; i < 66; i++) begin
         step("scan_d2b1");
         fd_cnt += int'(bus.frame_done);
      end
      chk("scan_d2b1.frames", 32'(fd_cnt), 32'd2);
      // Back-to-back rotation
      bus.mode = MODE_DIRECT;
      step("to_direct");
      start_scan(0, 0);
      for (int i = 0; i < 20; i++) step("scan_d0b0");
      // Abort while cur_addr = 4 in SHOW
      bus.scan_en = 1'b0;
      step("pre_abort");
      start_scan(1, 0);
      for (int i = 0; i < 40 && !(scanning && exp_addr == 3'd4); i++) step("abort_seek");
      chk("abort_at4", 32'(bus.cur_addr), 32'd4);
      bus.scan_en = 1'b0;
      bus.addr = 3'd6;
      step("abort");
      // g1 low for 10 cycles mid-scan; schedule must not pause
      start_scan(2, 1);
      for (int i = 0; i < 12; i++) step("g1_pre");
      bus.g1 = 1'b0;
      for (int i = 0; i < 10; i++) step("g1_low");
      bus.g1 = 1'b1;
      for (int i = 0; i < 12; i++) step("g1_back");
      // Randomized scan runs with enable noise, ended by mode = direct
      for (int r = 0; r < 4; r++) begin
         bus.mode = MODE_DIRECT;
         step("rand_gap");
         start_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         for (int i = 0; i < 50; i++) begin
            set_en(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0));
            bus.addr = 3'($urandom);
            step("scan_rand");
         end
      end
      // Async reset during BLANK
      set_en(1, 0, 0);
      bus.mode = MODE_DIRECT;
      step("pre_blank_rst");
      start_scan(1, 2);
      for (int i = 0; i < 20 && !(scanning && (pos % (d_run + 1 + b_run)) > d_run); i++) step("blank_seek");
      chk("blank_seek.busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      scanning = 1'b0;
      exp_y = 8'hFF;
      exp_addr = '0;
      exp_busy = 1'b0;
      exp_fd = 1'b0;
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) step("post_rst_scan");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_scan_138.md
Name: decode_scan_138

Overview:
- Parametrised, registered successor to the team's 74LS138-style 3-to-8 decoder.
- Decodes an ADDR_W-bit address into 2^ADDR_W active-low one-hot outputs, gated by '138-style enables (G1 active-high, G2A_n and G2B_n active-low).
- Mode 0 (direct): decodes the external address.
- Mode 1 (scan): an internal sequencer steps through all outputs with programmable dwell and blanking gaps. Used to drive LED/keypad row scanning.

Parameters:
- ADDR_W, 3, address width; output count N_OUT = 2^ADDR_W.
- DWELL_W, 8, width of the dwell-time input (cycles per step).
- BLANK_W, 4, width of the blank-gap input (cycles between steps).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- g1  in  1  enable, active-high.
- g2a_n  in  1  enable, active-low.
- g2b_n  in  1  enable, active-low.
- mode  in  1  0 = direct decode, 1 = scan.
- addr  in  ADDR_W  direct-mode address.
- scan_en  in  1  scan-mode run request, level.
- dwell  in  DWELL_W  step hold time minus one.
- blank  in  BLANK_W  gap between steps in cycles; 0 = no gap.
- y_n  out  N_OUT  decoded outputs, active-low, registered.
- cur_addr  out  ADDR_W  address currently selected by the sequencer.
- busy  out  1  high while the sequencer is in SHOW or BLANK.
- frame_done  out  1  one-cycle pulse when the last output's step completes.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). On assertion: y_n = all ones, cur_addr = 0, busy = 0, frame_done = 0, FSM = IDLE, counters = 0.
- en = g1 & ~g2a_n & ~g2b_n, evaluated combinationally and applied at the output register.
- All outputs are registered. Any input change is visible on y_n one clock later.
- Direct mode (mode = 0):
  - y_n[addr] = 0 and all other bits = 1 when en = 1.
  - y_n = all ones when en = 0.
  - Latency is 1 cycle. FSM is held in IDLE, cur_addr = 0, busy = 0.
- Scan FSM states: IDLE, SHOW, BLANK.
- IDLE -> SHOW when mode = 1 and scan_en = 1. On entry: cur_addr = 0, dwell_cnt loaded with dwell.
- SHOW:
  - y_n[cur_addr] = 0 if en, else all ones.
  - The step lasts dwell + 1 cycles; dwell = 0 gives a 1-cycle step. dwell_cnt decrements to 0.
  - At count 0: go to BLANK if blank != 0 (blank_cnt = blank − 1), else advance directly.
- BLANK: y_n = all ones for exactly blank cycles, then advance.
- Advance:
  - If cur_addr = N_OUT − 1: cur_addr wraps to 0 and frame_done pulses for 1 cycle, coincident with the first cycle of the next SHOW.
  - Otherwise cur_addr increments.
  - Either way, re-enter SHOW with dwell re-sampled. dwell and blank are sampled only at step start; changes mid-step take effect on the next step.
- The en = 0 condition during scan does not pause the sequencer. Counting continues and outputs are forced high only.
- scan_en = 0 or mode = 0 in SHOW/BLANK: abort to IDLE on the next edge. cur_addr = 0, no frame_done, y_n follows the direct-mode rule from that edge.
- busy = 1 exactly when the state is SHOW or BLANK.
- At most one y_n bit is low in any cycle, in every mode and state.
- Reset mid-scan: immediate return to reset values, no glitch low on y_n.

Decomposition:
- Shared package decode_pkg:
  - State enum (IDLE, SHOW, BLANK).
  - MODE_DIRECT = 0 and MODE_SCAN = 1 constants.
  - A one-hot-low decode function used here and by future decoders.
- One natural sub-module, decode_scan_seq: the FSM plus the dwell, blank and address counters. It outputs cur_addr, show_active, busy and frame_done.
- The top level holds the enable gating and the y_n register.

Test Plan:
- Reset with g1 = 1, g2a_n = g2b_n = 0, mode = 0, addr = 5 → y_n = 8'hFF during reset; 8'hDF one cycle after rst_n releases.
- Direct sweep: addr = 0..7 with enables active → y_n = FE, FD, FB, F7, EF, DF, BF, 7F, each 1 cycle after addr. Then set g2a_n = 1 → FF next cycle. Then set g1 = 0 → FF.
- Scan with dwell = 2, blank = 1, scan_en = 1:
  - Each address is held low for 3 cycles, followed by 1 cycle of FF.
  - Frame period is 32 cycles.
  - frame_done pulses once per 32 cycles, coincident with cur_addr returning to 0.
- Scan with dwell = 0, blank = 0 → y_n rotates FE→FD→…→7F every cycle. frame_done pulses every 8 cycles. busy stays 1.
- Mid-scan abort: drop scan_en while cur_addr = 4, in SHOW → next cycle busy = 0, cur_addr = 0, no frame_done, y_n follows addr.
- During scan, hold g1 = 0 for 10 cycles → y_n = FF throughout. cur_addr keeps advancing, so after g1 returns the selected bit matches the uninterrupted schedule. Also assert rst_n low mid-BLANK → all outputs return to reset values immediately.
